// File: rtl/icb_print_monitor.sv
// Passive ICB write snooper: captures print-channel byte writes into a shared FIFO
// drained over valid/ready, and latches RUN/PASS/FAIL from writes to a status address.
module icb_print_monitor #(
  parameter int unsigned NUM_CH      = 2,
  parameter logic [31:0] PRINT_BASE  = 32'h1004_0000,
  parameter logic [31:0] CH_STRIDE   = 32'h0000_0100,
  parameter logic [31:0] STATUS_ADDR = 32'h1004_1000,
  parameter logic [7:0]  PASS_CODE   = 8'd6,
  parameter logic [7:0]  FAIL_CODE   = 8'd4,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          icb_cmd_valid,
  input  logic                          icb_cmd_ready,
  input  logic [31:0]                   icb_cmd_addr,
  input  logic                          icb_cmd_read,
  input  logic [31:0]                   icb_cmd_wdata,
  input  logic [3:0]                    icb_cmd_wmask,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CH_W-1:0]               out_ch,
  output logic [7:0]                    out_char,
  output logic                          out_eol,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   ovf_cnt,
  output logic                          sim_done,
  output logic                          sim_pass,
  output logic                          sim_fail
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = CH_W + 9;

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic            wr_fire;
  logic            hit;
  logic [CH_W-1:0] hit_ch;
  logic            push_req;
  logic            push;
  logic            pop;
  logic            drop;
  logic            full;
  logic            status_fire;
  logic [7:0]      wbyte;
  logic [EW-1:0]   head;

  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [15:0]     ovf_q, ovf_d;
  state_t          state_q, state_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];

  logic            unused_ok;
  assign unused_ok = ^{icb_cmd_wdata[31:8], icb_cmd_wmask[3:1]};

  assign wr_fire = icb_cmd_valid & icb_cmd_ready & ~icb_cmd_read & icb_cmd_wmask[0];
  assign wbyte   = icb_cmd_wdata[7:0];

  // Only exact channel addresses match; gaps between channels are ignored.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (icb_cmd_addr == PRINT_BASE + 32'(k) * CH_STRIDE) begin
        hit    = 1'b1;
        hit_ch = CH_W'(k);
      end
    end
  end

  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign out_valid  = (wr_ptr_q != rd_ptr_q);
  assign pop        = out_valid & out_ready;
  assign push_req   = wr_fire & hit;
  // A pop frees the head slot at the same edge, so a full FIFO still takes the byte.
  assign push       = push_req & (~full | pop);
  assign drop       = push_req & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    ovf_d    = drop ? sat_inc(ovf_q) : ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {hit_ch, wbyte, (wbyte == 8'h0A)};
    end
  end

  // Head fields are forced to zero when empty so storage contents never leak out.
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign out_ch   = out_valid ? head[EW-1:9] : '0;
  assign out_char = out_valid ? head[8:1]    : 8'h00;
  assign out_eol  = out_valid ? head[0]      : 1'b0;
  assign ovf_cnt  = ovf_q;

  assign status_fire = wr_fire & (icb_cmd_addr == STATUS_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sim_done = (state_q != ST_RUN);
    sim_pass = (state_q == ST_PASS);
    sim_fail = (state_q == ST_FAIL);
    if (state_q == ST_RUN && status_fire) begin
      if (wbyte == PASS_CODE) begin
        state_d = ST_PASS;
      end else if (wbyte == FAIL_CODE) begin
        state_d = ST_FAIL;
      end
    end
  end

endmodule

// File: tb/tb_icb_print_monitor.sv
// Randomised scoreboard bench for icb_print_monitor with directed boundary sequences.
module tb_icb_print_monitor;

  localparam int unsigned NUM_CH      = 2;
  localparam logic [31:0] PRINT_BASE  = 32'h1004_0000;
  localparam logic [31:0] CH_STRIDE   = 32'h0000_0100;
  localparam logic [31:0] STATUS_ADDR = 32'h1004_1000;
  localparam logic [7:0]  PASS_CODE   = 8'd6;
  localparam logic [7:0]  FAIL_CODE   = 8'd4;
  localparam int unsigned FIFO_DEPTH  = 16;
  localparam int unsigned CH_W        = 1;

  logic                        clk;
  logic                        rst;
  logic                        icb_cmd_valid;
  logic                        icb_cmd_ready;
  logic [31:0]                 icb_cmd_addr;
  logic                        icb_cmd_read;
  logic [31:0]                 icb_cmd_wdata;
  logic [3:0]                  icb_cmd_wmask;
  logic                        out_valid;
  logic                        out_ready;
  logic [CH_W-1:0]             out_ch;
  logic [7:0]                  out_char;
  logic                        out_eol;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [15:0]                 ovf_cnt;
  logic                        sim_done;
  logic                        sim_pass;
  logic                        sim_fail;

  icb_print_monitor #(
    .NUM_CH(NUM_CH), .PRINT_BASE(PRINT_BASE), .CH_STRIDE(CH_STRIDE),
    .STATUS_ADDR(STATUS_ADDR), .PASS_CODE(PASS_CODE), .FAIL_CODE(FAIL_CODE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_char(out_char), .out_eol(out_eol), .fifo_level(fifo_level),
    .ovf_cnt(ovf_cnt), .sim_done(sim_done), .sim_pass(sim_pass), .sim_fail(sim_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [7:0]      c;
    logic            eol;
  } ent_t;

  ent_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_ovf = 0;
  int   m_state = 0;   // 0 running, 1 passed, 2 failed
  bit   pend_pop = 1'b0;
  bit   chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares the DUT against the queue model and consumes the head on a handshake.
  task automatic monitor();
    ent_t h;
    if (rst || !chk_en) return;
    chk("out_valid", {31'b0, out_valid}, (sb_q.size() != 0) ? 32'd1 : 32'd0);
    chk("fifo_level", 32'(fifo_level), 32'(sb_q.size()));
    chk("ovf_cnt", {16'b0, ovf_cnt}, 32'(m_ovf));
    chk("sim_done", {31'b0, sim_done}, (m_state != 0) ? 32'd1 : 32'd0);
    chk("sim_pass", {31'b0, sim_pass}, (m_state == 1) ? 32'd1 : 32'd0);
    chk("sim_fail", {31'b0, sim_fail}, (m_state == 2) ? 32'd1 : 32'd0);
    if (out_valid && sb_q.size() > 0) begin
      h = sb_q[0];
      chk("out_ch", 32'(out_ch), 32'(h.ch));
      chk("out_char", 32'(out_char), 32'(h.c));
      chk("out_eol", {31'b0, out_eol}, {31'b0, h.eol});
      if (out_ready) begin
        void'(sb_q.pop_front());
        pend_pop = 1'b1;
      end
    end
  endtask

  // Behavioural model: what the snooped transaction means at this clock edge.
  task automatic model();
    bit   fire;
    bit   hit;
    int   ch;
    int   occ;
    ent_t e;
    if (rst) begin
      sb_q.delete();
      m_ovf = 0;
      m_state = 0;
      pend_pop = 1'b0;
      return;
    end
    fire = icb_cmd_valid && icb_cmd_ready && !icb_cmd_read && icb_cmd_wmask[0];
    hit = 1'b0;
    ch = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (icb_cmd_addr == PRINT_BASE + 32'(k) * CH_STRIDE) begin
        hit = 1'b1;
        ch = k;
      end
    end
    if (fire && hit) begin
      occ = sb_q.size() + (pend_pop ? 1 : 0);
      if (occ < FIFO_DEPTH || pend_pop) begin
        e.ch = CH_W'(ch);
        e.c = icb_cmd_wdata[7:0];
        e.eol = (icb_cmd_wdata[7:0] == 8'h0A);
        sb_q.push_back(e);
      end else if (m_ovf < 65535) begin
        m_ovf++;
      end
    end
    if (fire && icb_cmd_addr == STATUS_ADDR && m_state == 0) begin
      if (icb_cmd_wdata[7:0] == PASS_CODE) m_state = 1;
      else if (icb_cmd_wdata[7:0] == FAIL_CODE) m_state = 2;
    end
    pend_pop = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    model();
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic [31:0] a, input logic rd,
                       input logic [31:0] wd, input logic [3:0] wm, input logic ordy);
    icb_cmd_valid = v;
    icb_cmd_ready = r;
    icb_cmd_addr  = a;
    icb_cmd_read  = rd;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = wm;
    out_ready     = ordy;
    tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] b, input logic ordy);
    drive(1'b1, 1'b1, a, 1'b0, {24'h5A5A5A, b}, 4'hF, ordy);
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, ordy);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 5) return PRINT_BASE + 32'($urandom_range(0, NUM_CH - 1)) * CH_STRIDE;
    if (sel == 5) return STATUS_ADDR;
    if (sel == 6) return PRINT_BASE + 32'(NUM_CH) * CH_STRIDE;
    if (sel == 7) return PRINT_BASE + 32'h4;
    return $urandom();
  endfunction

  function automatic logic [7:0] rand_byte();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 2) return 8'h0A;
    if (sel < 4) return 8'($urandom_range(4, 6));
    return 8'($urandom());
  endfunction

  initial begin
    logic ordy_mode;
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    chk_en = 1'b1;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst out_ch", 32'(out_ch), 32'd0);
    chk("rst out_char", 32'(out_char), 32'd0);
    chk("rst out_eol", {31'b0, out_eol}, 32'd0);
    chk("rst fifo_level", 32'(fifo_level), 32'd0);
    chk("rst ovf_cnt", {16'b0, ovf_cnt}, 32'd0);
    chk("rst sim_done", {31'b0, sim_done}, 32'd0);
    chk("rst sim_pass", {31'b0, sim_pass}, 32'd0);
    chk("rst sim_fail", {31'b0, sim_fail}, 32'd0);
    rst = 1'b0;

    // Simple line on channel 0.
    wr(PRINT_BASE, 8'h48, 1'b1);
    chk("t1 first valid", {31'b0, out_valid}, 32'd1);
    chk("t1 first char", 32'(out_char), 32'h48);
    chk("t1 first eol", {31'b0, out_eol}, 32'd0);
    wr(PRINT_BASE, 8'h69, 1'b1);
    wr(PRINT_BASE, 8'h0A, 1'b1);
    chk("t1 eol char", {31'b0, out_eol}, 32'd1);
    idle(1'b1);
    idle(1'b1);

    // Channel interleave and an address just past the last channel.
    wr(PRINT_BASE + CH_STRIDE, 8'h41, 1'b1);
    chk("t2 ch1", 32'(out_ch), 32'd1);
    chk("t2 char A", 32'(out_char), 32'h41);
    wr(PRINT_BASE, 8'h42, 1'b1);
    wr(PRINT_BASE + 32'(NUM_CH) * CH_STRIDE, 8'h43, 1'b1);
    chk("t2 out of range level", 32'(fifo_level), 32'd0);

    // Overflow with a stalled sink.
    for (int i = 0; i < 20; i++) wr(PRINT_BASE, 8'h30 + 8'(i), 1'b0);
    chk("t3 level full", 32'(fifo_level), 32'd16);
    chk("t3 ovf", {16'b0, ovf_cnt}, 32'd4);
    chk("t3 head byte0", 32'(out_char), 32'h30);

    // Push and pop together while full.
    wr(PRINT_BASE, 8'h5A, 1'b1);
    idle(1'b0);
    chk("t4 level", 32'(fifo_level), 32'd16);
    chk("t4 ovf", {16'b0, ovf_cnt}, 32'd4);
    for (int i = 0; i < 15; i++) idle(1'b1);
    chk("t4 last out", 32'(out_char), 32'h5A);
    chk("t4 last level", 32'(fifo_level), 32'd1);
    idle(1'b1);
    idle(1'b1);

    // Non-capturing transactions, then reset with data queued and status latched.
    drive(1'b1, 1'b0, PRINT_BASE, 1'b0, 32'h61, 4'hF, 1'b0);
    drive(1'b1, 1'b1, PRINT_BASE, 1'b1, 32'h62, 4'hF, 1'b0);
    drive(1'b1, 1'b1, PRINT_BASE, 1'b0, 32'h63, 4'hE, 1'b0);
    chk("t6 ignored level", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 5; i++) wr(PRINT_BASE + CH_STRIDE, 8'h70 + 8'(i), 1'b0);
    chk("t6 level 5", 32'(fifo_level), 32'd5);
    wr(STATUS_ADDR, PASS_CODE, 1'b0);
    chk("t6 pass before rst", {31'b0, sim_pass}, 32'd1);
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    chk("t6 rst valid", {31'b0, out_valid}, 32'd0);
    chk("t6 rst level", 32'(fifo_level), 32'd0);
    chk("t6 rst ovf", {16'b0, ovf_cnt}, 32'd0);
    chk("t6 rst done", {31'b0, sim_done}, 32'd0);

    // Status sequencing.
    wr(STATUS_ADDR, 8'd5, 1'b1);
    chk("t5 code5 done", {31'b0, sim_done}, 32'd0);
    wr(STATUS_ADDR, PASS_CODE, 1'b1);
    chk("t5 pass done", {31'b0, sim_done}, 32'd1);
    chk("t5 pass", {31'b0, sim_pass}, 32'd1);
    wr(STATUS_ADDR, FAIL_CODE, 1'b1);
    chk("t5 fail sticky", {31'b0, sim_fail}, 32'd0);
    chk("t5 pass sticky", {31'b0, sim_pass}, 32'd1);
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;

    // Randomised traffic with stall phases and occasional reset.
    ordy_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) ordy_mode = ~ordy_mode;
      rst = ($urandom_range(0, 499) == 0);
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 8), rand_addr(),
            ($urandom_range(0, 9) == 0), {$urandom_range(0, 255) == 0 ? 24'h0 : 24'($urandom()), rand_byte()},
            {3'($urandom()), ($urandom_range(0, 4) != 0)},
            ordy_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0));
      rst = 1'b0;
    end
    for (int i = 0; i < 40; i++) idle(1'b1);
    chk("drain level", 32'(fifo_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
